// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice definitions: velocity set, sweep FSM states, accumulator ops.
package lbm_pkg;

    localparam int unsigned Q       = 9;
    localparam int unsigned DIR_W   = 4;
    localparam int unsigned GUARD_W = 4;

    // Lattice velocity components per direction 0..8.
    localparam logic signed [1:0] EX [Q] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0,
                                             2'sd1, -2'sd1, -2'sd1, 2'sd1};
    localparam logic signed [1:0] EY [Q] = '{2'sd0, 2'sd0, 2'sd1, 2'sd0, -2'sd1,
                                             2'sd1, 2'sd1, -2'sd1, -2'sd1};

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} sweep_state_t;

    typedef enum logic [1:0] {OP_HOLD, OP_ADD, OP_SUB} acc_op_t;

    // Map a velocity component to the accumulator operation it implies.
    function automatic acc_op_t vel_op(input logic signed [1:0] e);
        acc_op_t op;
        op = OP_HOLD;
        if (e == 2'sd1) begin
            op = OP_ADD;
        end else if (e == -2'sd1) begin
            op = OP_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/moment_accum.sv
// One signed moment accumulator lane with guard bits and output saturation.
//  clk, reset : clock, synchronous active-high reset
//  clr        : clear the accumulator (takes priority over op)
//  op         : add / subtract / hold din
//  din        : signed population sample
//  res_c      : saturated view of the accumulator's next value
//  ovf_c      : res_c was clamped
module moment_accum
    import lbm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  acc_op_t                      op,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] res_c,
    output logic                         ovf_c
);

    localparam int unsigned AW = DATA_WIDTH + GUARD_W;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] din_ext;
    logic [GUARD_W:0]     top_bits;
    logic                 in_range;

    always_comb begin
        din_ext = {{GUARD_W{din[DATA_WIDTH-1]}}, din};
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else begin
            case (op)
                OP_ADD:  acc_d = acc_q + din_ext;
                OP_SUB:  acc_d = acc_q - din_ext;
                default: acc_d = acc_q;
            endcase
        end
    end

    // In range when the guard bits plus the result sign bit all agree.
    always_comb begin
        top_bits = acc_d[AW-1:DATA_WIDTH-1];
        in_range = (&top_bits) | ~(|top_bits);
        ovf_c    = ~in_range;
        if (in_range) begin
            res_c = acc_d[DATA_WIDTH-1:0];
        end else if (acc_d[AW-1]) begin
            res_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/moment_sweep.sv
// D2Q9 moment extraction: sweeps all lattice nodes, reads f0..f8 from the
// population RAM and writes saturated rho/jx/jy to the moment RAMs.
//  Clk, Reset : clock, synchronous active-high reset
//  start      : begin a sweep when idle
//  busy/done  : sweep in progress / one-cycle completion pulse
//  sat        : sticky saturation flag for the current sweep
//  pop_addr   : {dir, node} read address, pop_data returns one cycle later
//  mom_addr, mom_we, rho_out, jx_out, jy_out : moment RAM write port
module moment_sweep
    import lbm_pkg::*;
#(
    parameter int unsigned NX            = 16,
    parameter int unsigned NY            = 16,
    parameter int unsigned DEPTH         = NX * NY,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             sat,
    output logic [DIR_W+ADDRESS_WIDTH-1:0]   pop_addr,
    input  logic signed [DATA_WIDTH-1:0]     pop_data,
    output logic [ADDRESS_WIDTH-1:0]         mom_addr,
    output logic                             mom_we,
    output logic signed [DATA_WIDTH-1:0]     rho_out,
    output logic signed [DATA_WIDTH-1:0]     jx_out,
    output logic signed [DATA_WIDTH-1:0]     jy_out
);

    localparam logic [DIR_W-1:0]         LAST_DIR  = DIR_W'(Q - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_NODE = ADDRESS_WIDTH'(DEPTH - 1);

    sweep_state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]         node_q, node_d, node_inc;
    logic [DIR_W-1:0]                 dir_q, dir_d, dir_inc;
    logic [DIR_W-1:0]                 dir_dly_q, dir_dly_d;
    logic                             vld_dly_q, vld_dly_d;
    logic [DIR_W+ADDRESS_WIDTH-1:0]   pop_addr_q, pop_addr_d;
    logic [ADDRESS_WIDTH-1:0]         mom_addr_q, mom_addr_d;
    logic                             mom_we_q, mom_we_d;
    logic signed [DATA_WIDTH-1:0]     rho_q, rho_d, jx_q, jx_d, jy_q, jy_d;
    logic                             busy_q, busy_d, done_q, done_d, sat_q, sat_d;

    logic                             acc_clr_c;
    acc_op_t                          rho_op_c, jx_op_c, jy_op_c;
    logic signed [DATA_WIDTH-1:0]     rho_res_c, jx_res_c, jy_res_c;
    logic                             rho_ovf_c, jx_ovf_c, jy_ovf_c;

    // Delayed dir tags pop_data with the direction it was issued for.
    always_comb begin
        acc_clr_c = (state_q == IDLE) || (state_q == WRITE);
        rho_op_c  = OP_HOLD;
        jx_op_c   = OP_HOLD;
        jy_op_c   = OP_HOLD;
        if (vld_dly_q) begin
            rho_op_c = OP_ADD;
            jx_op_c  = vel_op(EX[dir_dly_q]);
            jy_op_c  = vel_op(EY[dir_dly_q]);
        end
    end

    moment_accum #(.DATA_WIDTH(DATA_WIDTH)) u_rho (
        .clk(Clk), .reset(Reset), .clr(acc_clr_c), .op(rho_op_c),
        .din(pop_data), .res_c(rho_res_c), .ovf_c(rho_ovf_c)
    );
    moment_accum #(.DATA_WIDTH(DATA_WIDTH)) u_jx (
        .clk(Clk), .reset(Reset), .clr(acc_clr_c), .op(jx_op_c),
        .din(pop_data), .res_c(jx_res_c), .ovf_c(jx_ovf_c)
    );
    moment_accum #(.DATA_WIDTH(DATA_WIDTH)) u_jy (
        .clk(Clk), .reset(Reset), .clr(acc_clr_c), .op(jy_op_c),
        .din(pop_data), .res_c(jy_res_c), .ovf_c(jy_ovf_c)
    );

    // Next-state and registered-output logic. Outputs are loaded one state
    // early so they are valid in the state that owns them; the DRAIN cycle
    // folds in f8 and the sums land on the outputs for WRITE.
    always_comb begin
        state_d    = state_q;
        node_d     = node_q;
        dir_d      = dir_q;
        pop_addr_d = pop_addr_q;
        mom_addr_d = mom_addr_q;
        mom_we_d   = 1'b0;
        rho_d      = rho_q;
        jx_d       = jx_q;
        jy_d       = jy_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sat_d      = sat_q;
        dir_dly_d  = dir_q;
        vld_dly_d  = (state_q == ISSUE);
        dir_inc    = dir_q + DIR_W'(1);
        node_inc   = node_q + ADDRESS_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    node_d     = '0;
                    dir_d      = '0;
                    sat_d      = 1'b0;
                    busy_d     = 1'b1;
                    pop_addr_d = '0;
                end
            end
            ISSUE: begin
                if (dir_q == LAST_DIR) begin
                    state_d = DRAIN;
                end else begin
                    dir_d      = dir_inc;
                    pop_addr_d = {dir_inc, node_q};
                end
            end
            DRAIN: begin
                state_d    = WRITE;
                mom_we_d   = 1'b1;
                mom_addr_d = node_q;
                rho_d      = rho_res_c;
                jx_d       = jx_res_c;
                jy_d       = jy_res_c;
                sat_d      = sat_q | rho_ovf_c | jx_ovf_c | jy_ovf_c;
            end
            WRITE: begin
                if (node_q == LAST_NODE) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ISSUE;
                    node_d     = node_inc;
                    dir_d      = '0;
                    pop_addr_d = {DIR_W'(0), node_inc};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            node_q     <= '0;
            dir_q      <= '0;
            dir_dly_q  <= '0;
            vld_dly_q  <= 1'b0;
            pop_addr_q <= '0;
            mom_addr_q <= '0;
            mom_we_q   <= 1'b0;
            rho_q      <= '0;
            jx_q       <= '0;
            jy_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            node_q     <= node_d;
            dir_q      <= dir_d;
            dir_dly_q  <= dir_dly_d;
            vld_dly_q  <= vld_dly_d;
            pop_addr_q <= pop_addr_d;
            mom_addr_q <= mom_addr_d;
            mom_we_q   <= mom_we_d;
            rho_q      <= rho_d;
            jx_q       <= jx_d;
            jy_q       <= jy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sat      = sat_q;
    assign pop_addr = pop_addr_q;
    assign mom_addr = mom_addr_q;
    assign mom_we   = mom_we_q;
    assign rho_out  = rho_q;
    assign jx_out   = jx_q;
    assign jy_out   = jy_q;

endmodule
